// File: rtl/instr_ram_arbiter_if.sv
// Bundle of the fetch port, loader port and instruction-RAM port seen by instr_ram_arbiter.
// The slave modport is the arbiter's view; master is the requester/memory side.
interface instr_ram_arbiter_if #(
    parameter int ADDR_WIDTH = 18,
    parameter int DATA_WIDTH = 32
);
    logic                      p0_req_i;
    logic [ADDR_WIDTH-1:0]     p0_addr_i;
    logic                      p0_gnt_o;
    logic                      p0_rvalid_o;
    logic [DATA_WIDTH-1:0]     p0_rdata_o;

    logic                      p1_req_i;
    logic [ADDR_WIDTH-1:0]     p1_addr_i;
    logic                      p1_we_i;
    logic [DATA_WIDTH/8-1:0]   p1_be_i;
    logic [DATA_WIDTH-1:0]     p1_wdata_i;
    logic                      p1_gnt_o;
    logic                      p1_rvalid_o;
    logic [DATA_WIDTH-1:0]     p1_rdata_o;
    logic                      p1_err_o;

    logic                      mem_en_o;
    logic [ADDR_WIDTH-1:0]     mem_addr_o;
    logic                      mem_we_o;
    logic [DATA_WIDTH/8-1:0]   mem_be_o;
    logic [DATA_WIDTH-1:0]     mem_wdata_o;
    logic [DATA_WIDTH-1:0]     mem_rdata_i;

    modport slave (
        input  p0_req_i, p0_addr_i,
        output p0_gnt_o, p0_rvalid_o, p0_rdata_o,
        input  p1_req_i, p1_addr_i, p1_we_i, p1_be_i, p1_wdata_i,
        output p1_gnt_o, p1_rvalid_o, p1_rdata_o, p1_err_o,
        output mem_en_o, mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o,
        input  mem_rdata_i
    );

    modport master (
        output p0_req_i, p0_addr_i,
        input  p0_gnt_o, p0_rvalid_o, p0_rdata_o,
        output p1_req_i, p1_addr_i, p1_we_i, p1_be_i, p1_wdata_i,
        input  p1_gnt_o, p1_rvalid_o, p1_rdata_o, p1_err_o,
        input  mem_en_o, mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o,
        output mem_rdata_i
    );
endinterface

// File: rtl/instr_ram_arbiter.sv
// Two-port arbiter in front of the single-port instruction RAM: fetch (port 0) has priority,
// loader (port 1) is guaranteed a grant after STARVE_LIMIT denied cycles.
module instr_ram_arbiter #(
    parameter int ADDR_WIDTH   = 18,
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    instr_ram_arbiter_if.slave   bus
);
    localparam int         BE_WIDTH   = DATA_WIDTH / 8;
    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    logic [3:0]            starve_cnt_r;
    logic                  resp_valid_r;
    logic                  resp_owner_r;
    logic                  resp_write_r;
    logic                  resp_drop_r;

    logic                  p0_gnt_s;
    logic                  p1_gnt_s;
    logic                  p1_drop_s;
    logic                  mem_en_s;
    logic [ADDR_WIDTH-1:0] mem_addr_s;
    logic                  mem_we_s;
    logic [BE_WIDTH-1:0]   mem_be_s;
    logic [DATA_WIDTH-1:0] mem_wdata_s;
    logic                  p0_rvalid_s;
    logic                  p1_rvalid_s;

    // Grant decision; gated by rst so nothing is granted while reset is held.
    always_comb begin
        p0_gnt_s = 1'b0;
        p1_gnt_s = 1'b0;
        if (rst) begin
            p0_gnt_s = 1'b0;
            p1_gnt_s = 1'b0;
        end else if (bus.p1_req_i && (!bus.p0_req_i || (starve_cnt_r == STARVE_MAX))) begin
            p1_gnt_s = 1'b1;
        end else if (bus.p0_req_i) begin
            p0_gnt_s = 1'b1;
        end else begin
            p0_gnt_s = 1'b0;
            p1_gnt_s = 1'b0;
        end
        // Loader writes into the boot-ROM window are acknowledged but never reach memory.
        p1_drop_s = p1_gnt_s && bus.p1_we_i && bus.p1_addr_i[ADDR_WIDTH-1];
    end

    // Memory-side mux: the granted port drives the RAM in the grant cycle.
    always_comb begin
        mem_en_s    = 1'b0;
        mem_addr_s  = {ADDR_WIDTH{1'b0}};
        mem_we_s    = 1'b0;
        mem_be_s    = {BE_WIDTH{1'b0}};
        mem_wdata_s = {DATA_WIDTH{1'b0}};
        if (p0_gnt_s) begin
            mem_en_s    = 1'b1;
            mem_addr_s  = bus.p0_addr_i;
            mem_we_s    = 1'b0;
            mem_be_s    = {BE_WIDTH{1'b1}};
        end else if (p1_gnt_s) begin
            mem_en_s    = !p1_drop_s;
            mem_addr_s  = bus.p1_addr_i;
            mem_we_s    = bus.p1_we_i;
            mem_be_s    = bus.p1_be_i;
            mem_wdata_s = bus.p1_wdata_i;
        end else begin
            mem_en_s    = 1'b0;
        end
    end

    // Starvation counter: counts denied loader cycles, cleared on grant or when the loader idles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt_r <= 4'd0;
        end else if (!bus.p1_req_i || p1_gnt_s) begin
            starve_cnt_r <= 4'd0;
        end else if (starve_cnt_r != STARVE_MAX) begin
            starve_cnt_r <= starve_cnt_r + 4'd1;
        end else begin
            starve_cnt_r <= starve_cnt_r;
        end
    end

    // One-deep response pipeline matching the RAM's 1-cycle read latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_valid_r <= 1'b0;
            resp_owner_r <= 1'b0;
            resp_write_r <= 1'b0;
            resp_drop_r  <= 1'b0;
        end else begin
            resp_valid_r <= p0_gnt_s || p1_gnt_s;
            resp_owner_r <= p1_gnt_s;
            resp_write_r <= p1_gnt_s && bus.p1_we_i;
            resp_drop_r  <= p1_drop_s;
        end
    end

    assign p0_rvalid_s     = resp_valid_r && !resp_owner_r;
    assign p1_rvalid_s     = resp_valid_r && resp_owner_r;

    assign bus.p0_gnt_o    = p0_gnt_s;
    assign bus.p1_gnt_o    = p1_gnt_s;
    assign bus.mem_en_o    = mem_en_s;
    assign bus.mem_addr_o  = mem_addr_s;
    assign bus.mem_we_o    = mem_we_s;
    assign bus.mem_be_o    = mem_be_s;
    assign bus.mem_wdata_o = mem_wdata_s;

    assign bus.p0_rvalid_o = p0_rvalid_s;
    assign bus.p0_rdata_o  = p0_rvalid_s ? bus.mem_rdata_i : {DATA_WIDTH{1'b0}};
    assign bus.p1_rvalid_o = p1_rvalid_s;
    assign bus.p1_rdata_o  = (p1_rvalid_s && !resp_write_r) ? bus.mem_rdata_i : {DATA_WIDTH{1'b0}};
    assign bus.p1_err_o    = p1_rvalid_s && resp_drop_r;
endmodule

// File: tb/tb_instr_ram_arbiter.sv
// Self-checking bench for instr_ram_arbiter: vector table for the grant-cycle outputs,
// response scoreboard checked one cycle later, plus reset sequences.
module tb_instr_ram_arbiter;
    localparam int AW = 18;
    localparam int DW = 32;

    typedef struct {
        logic          p0_req;
        logic [AW-1:0] p0_addr;
        logic          p1_req;
        logic [AW-1:0] p1_addr;
        logic          p1_we;
        logic [3:0]    p1_be;
        logic [DW-1:0] p1_wdata;
        logic          e_p0_gnt;
        logic          e_p1_gnt;
        logic          e_en;
    } vec_t;

    typedef struct {
        logic          valid;
        logic          owner;
        logic [DW-1:0] data;
        logic          err;
    } resp_t;

    logic  clk;
    logic  rst;
    int    total;
    int    bad;
    vec_t  vecs[$];
    resp_t sbq[$];

    instr_ram_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    instr_ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model content: 0x00100 reads back 0xDEADBEEF, every other address differs.
    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        return 32'hDEADBEEF ^ {14'd0, a} ^ 32'h0000_0100;
    endfunction

    // RAM model: returns the word at the address presented on the previous edge.
    always @(posedge clk) bus.mem_rdata_i <= mem_word(bus.mem_addr_o);

    function automatic vec_t mk(input logic p0r, input logic [AW-1:0] p0a,
                                input logic p1r, input logic [AW-1:0] p1a, input logic we,
                                input logic [3:0] be, input logic [DW-1:0] wd,
                                input logic g0, input logic g1, input logic en);
        vec_t v;
        v.p0_req = p0r; v.p0_addr = p0a; v.p1_req = p1r; v.p1_addr = p1a;
        v.p1_we = we; v.p1_be = be; v.p1_wdata = wd;
        v.e_p0_gnt = g0; v.e_p1_gnt = g1; v.e_en = en;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_resp(input string tag);
        resp_t e;
        e = '{1'b0, 1'b0, 32'd0, 1'b0};
        if (sbq.size() != 0) e = sbq.pop_front();
        chk({tag, " p0_rvalid"}, 64'(bus.p0_rvalid_o), 64'(e.valid && !e.owner));
        chk({tag, " p1_rvalid"}, 64'(bus.p1_rvalid_o), 64'(e.valid && e.owner));
        chk({tag, " p0_rdata"}, 64'(bus.p0_rdata_o), (e.valid && !e.owner) ? 64'(e.data) : 64'd0);
        chk({tag, " p1_rdata"}, 64'(bus.p1_rdata_o), (e.valid && e.owner) ? 64'(e.data) : 64'd0);
        chk({tag, " p1_err"}, 64'(bus.p1_err_o), 64'(e.valid && e.owner && e.err));
    endtask

    task automatic apply(input vec_t v, input string tag);
        resp_t r;
        @(negedge clk);
        check_resp(tag);
        bus.p0_req_i = v.p0_req;   bus.p0_addr_i = v.p0_addr;
        bus.p1_req_i = v.p1_req;   bus.p1_addr_i = v.p1_addr;
        bus.p1_we_i = v.p1_we;     bus.p1_be_i = v.p1_be;
        bus.p1_wdata_i = v.p1_wdata;
        #1;
        chk({tag, " p0_gnt"}, 64'(bus.p0_gnt_o), 64'(v.e_p0_gnt));
        chk({tag, " p1_gnt"}, 64'(bus.p1_gnt_o), 64'(v.e_p1_gnt));
        chk({tag, " mem_en"}, 64'(bus.mem_en_o), 64'(v.e_en));
        if (v.e_en && v.e_p0_gnt) begin
            chk({tag, " mem_addr"}, 64'(bus.mem_addr_o), 64'(v.p0_addr));
            chk({tag, " mem_we"}, 64'(bus.mem_we_o), 64'd0);
            chk({tag, " mem_be"}, 64'(bus.mem_be_o), 64'hF);
        end
        if (v.e_en && v.e_p1_gnt) begin
            chk({tag, " mem_addr"}, 64'(bus.mem_addr_o), 64'(v.p1_addr));
            chk({tag, " mem_we"}, 64'(bus.mem_we_o), 64'(v.p1_we));
            chk({tag, " mem_be"}, 64'(bus.mem_be_o), 64'(v.p1_be));
            if (v.p1_we) chk({tag, " mem_wdata"}, 64'(bus.mem_wdata_o), 64'(v.p1_wdata));
        end
        r.valid = v.e_p0_gnt || v.e_p1_gnt;
        r.owner = v.e_p1_gnt;
        r.err   = v.e_p1_gnt && v.p1_we && v.p1_addr[AW-1];
        if (v.e_p0_gnt)                 r.data = mem_word(v.p0_addr);
        else if (v.e_p1_gnt && !v.p1_we) r.data = mem_word(v.p1_addr);
        else                            r.data = 32'd0;
        sbq.push_back(r);
    endtask

    initial begin
        vec_t idle;
        total = 0;
        bad   = 0;
        idle  = mk(1'b0, 18'h0, 1'b0, 18'h0, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0, 1'b0);

        // Reset held with both ports requesting: everything must read 0.
        rst = 1'b1;
        bus.p0_req_i = 1'b1; bus.p0_addr_i = 18'h00100;
        bus.p1_req_i = 1'b1; bus.p1_addr_i = 18'h00040;
        bus.p1_we_i = 1'b0;  bus.p1_be_i = 4'hF; bus.p1_wdata_i = 32'h0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            chk("rst p0_gnt", 64'(bus.p0_gnt_o), 64'd0);
            chk("rst p1_gnt", 64'(bus.p1_gnt_o), 64'd0);
            chk("rst mem_en", 64'(bus.mem_en_o), 64'd0);
            chk("rst p0_rvalid", 64'(bus.p0_rvalid_o), 64'd0);
            chk("rst p1_rvalid", 64'(bus.p1_rvalid_o), 64'd0);
            chk("rst p1_err", 64'(bus.p1_err_o), 64'd0);
        end
        bus.p0_req_i = 1'b0;
        bus.p1_req_i = 1'b0;
        rst = 1'b0;

        vecs.push_back(idle);
        vecs.push_back(mk(1'b1, 18'h00100, 1'b0, 18'h0, 1'b0, 4'h0, 32'h0, 1'b1, 1'b0, 1'b1));
        vecs.push_back(mk(1'b0, 18'h0, 1'b1, 18'h00040, 1'b1, 4'b0011, 32'h1234ABCD, 1'b0, 1'b1, 1'b1));
        vecs.push_back(mk(1'b0, 18'h0, 1'b1, 18'h00080, 1'b0, 4'hF, 32'h0, 1'b0, 1'b1, 1'b1));
        vecs.push_back(mk(1'b0, 18'h0, 1'b1, 18'h20010, 1'b1, 4'hF, 32'hCAFEF00D, 1'b0, 1'b1, 1'b0));
        vecs.push_back(mk(1'b0, 18'h0, 1'b1, 18'h20020, 1'b0, 4'hF, 32'h0, 1'b0, 1'b1, 1'b1));
        vecs.push_back(mk(1'b1, 18'h20004, 1'b0, 18'h0, 1'b0, 4'h0, 32'h0, 1'b1, 1'b0, 1'b1));
        // Continuous contention: four fetches, one forced loader grant, then fetch again.
        for (int i = 0; i < 6; i++)
            vecs.push_back(mk(1'b1, 18'(18'h00200 + 4 * i), 1'b1, 18'h00300, 1'b0, 4'hF, 32'h0,
                              (i != 4) ? 1'b1 : 1'b0, (i == 4) ? 1'b1 : 1'b0, 1'b1));
        vecs.push_back(idle);
        vecs.push_back(mk(1'b1, 18'h00400, 1'b1, 18'h00500, 1'b1, 4'b1100, 32'h55AA55AA, 1'b1, 1'b0, 1'b1));
        vecs.push_back(mk(1'b0, 18'h0, 1'b1, 18'h00500, 1'b1, 4'b1100, 32'h55AA55AA, 1'b0, 1'b1, 1'b1));
        vecs.push_back(idle);

        foreach (vecs[i]) apply(vecs[i], $sformatf("v%0d", i));

        // Reset asserted while a fetch response is pending: it must be discarded.
        apply(mk(1'b1, 18'h00180, 1'b0, 18'h0, 1'b0, 4'h0, 32'h0, 1'b1, 1'b0, 1'b1), "rm_grant");
        @(posedge clk); #1;
        rst = 1'b1;
        sbq.delete();
        #1;
        chk("rm p0_rvalid", 64'(bus.p0_rvalid_o), 64'd0);
        chk("rm p0_rdata", 64'(bus.p0_rdata_o), 64'd0);
        apply(idle, "rm_hold0");
        apply(idle, "rm_hold1");
        rst = 1'b0;
        apply(idle, "rm_after");
        apply(mk(1'b1, 18'h001C0, 1'b0, 18'h0, 1'b0, 4'h0, 32'h0, 1'b1, 1'b0, 1'b1), "rm_new");
        apply(idle, "rm_resp");
        apply(idle, "rm_tail");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/instr_ram_arbiter.md
Name: instr_ram_arbiter

Overview:
- Shares the single-port instruction memory (RAM plus boot ROM window) between two requesters.
- Port 0 is core instruction fetch: read-only, high priority.
- Port 1 is the debug/loader bus: read/write, low priority, with anti-starvation.
- Sits directly in front of the instruction RAM wrapper. Drives its en/addr/we/be/wdata and routes the 1-cycle-latency read data back to whichever port owns it.

Parameters:
- ADDR_WIDTH, 18, byte address width incl. MSB boot-ROM select bit (1 = boot ROM window).
- DATA_WIDTH, 32, data bus width; be width = DATA_WIDTH/8.
- STARVE_LIMIT, 4, consecutive cycles port 1 may be denied while requesting before it is forced a grant; range 1..15.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- p0_req_i  in  1  fetch request.
- p0_addr_i  in  ADDR_WIDTH  fetch byte address.
- p0_gnt_o  out  1  fetch accepted this cycle.
- p0_rvalid_o  out  1  fetch data valid.
- p0_rdata_o  out  DATA_WIDTH  fetch data.
- p1_req_i  in  1  loader request.
- p1_addr_i  in  ADDR_WIDTH  loader byte address.
- p1_we_i  in  1  1 = write.
- p1_be_i  in  DATA_WIDTH/8  byte enables.
- p1_wdata_i  in  DATA_WIDTH  write data.
- p1_gnt_o  out  1  loader accepted this cycle.
- p1_rvalid_o  out  1  loader response valid (read data or write ack).
- p1_rdata_o  out  DATA_WIDTH  loader read data (0 on write ack).
- p1_err_o  out  1  with p1_rvalid_o: rejected write to boot-ROM window.
- mem_en_o  out  1  memory enable.
- mem_addr_o  out  ADDR_WIDTH  memory address.
- mem_we_o  out  1  memory write.
- mem_be_o  out  DATA_WIDTH/8  memory byte enables.
- mem_wdata_o  out  DATA_WIDTH  memory write data.
- mem_rdata_i  in  DATA_WIDTH  memory read data, valid 1 cycle after en.

Behaviour:
- Reset (async assert, sync release): all registered state cleared; starve_cnt=0; both rvalid=0; p1_err_o=0. All outputs read 0 while rst=1.
- Grant decision is combinational in the request cycle; at most one gnt per cycle.
  - Default priority is port 0. Port 1 wins if p0_req_i=0, or if starve_cnt==STARVE_LIMIT.
  - gnt is never asserted without the matching req.
- starve_cnt (4 bits):
  - Increments each cycle p1_req_i=1 and p1_gnt_o=0, saturating at STARVE_LIMIT.
  - Cleared on any p1 grant, or any cycle p1_req_i=0.
- Granted port drives the mem_* outputs that cycle. mem_en_o=1 iff a grant occurs and the access is not dropped. Port 0 always has mem_we_o=0 and mem_be_o=all ones.
- Dropped access: a p1 write with addr MSB=1 (boot-ROM window).
  - Grant is still given, but mem_en_o=0.
  - Next cycle: p1_rvalid_o=1, p1_err_o=1, p1_rdata_o=0.
- Response pipeline: a 1-cycle register holds owner (0/1), is_write and dropped flags.
  - Cycle after a grant: exactly one rvalid pulses for one cycle, on the owning port.
  - p*_rdata_o = mem_rdata_i on a read response, else 0.
  - The non-owning port's rvalid=0 and rdata=0.
- Back-to-back grants are allowed every cycle; throughput is 1 access/cycle. Responses are in grant order.
- Requesters hold req/addr/wdata stable until gnt. The arbiter does not buffer ungranted requests.
- Reset asserted mid-transaction: pending response discarded. No rvalid follows the reset release.

Test Plan:
- Reset then idle: rst=1 for 3 cycles, release -> all outputs 0, mem_en_o=0.
- Port 0 read of 0x00100: p0_req=1 -> p0_gnt=1 and mem_addr_o=0x00100 same cycle; next cycle p0_rvalid=1 and p0_rdata=mem_rdata_i (0xDEADBEEF).
- Port 1 write 0x0000_0040, be=4'b0011, wdata=0x1234ABCD, port 0 idle -> p1_gnt=1; mem_we=1, mem_be=0011; next cycle p1_rvalid=1, p1_err=0, p1_rdata=0.
- Contention with STARVE_LIMIT=4: both ports request continuously -> p0 granted cycles 0-3, p1 granted cycle 4, p0 granted cycle 5.
- Boot-window write: p1 write to 0x20010 (MSB set) -> p1_gnt=1, mem_en_o=0; next cycle p1_rvalid=1, p1_err=1.
- Reset mid-op: p0 granted, rst asserted before the next edge -> p0_rvalid stays 0; after release the first new grant behaves normally.
